// File: rtl/rf_pkg.sv
// Shared defaults and handy types for the multi-port register file with scoreboard.
package rf_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: release/reserve/flush priority, read-side busy lookup with
// same-cycle release bypass, and a registered count of busy registers.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NRD-1:0][AW-1:0] rd_addr_i,
    output logic [NRD-1:0]         rd_busy_o,
    input  logic [NWR-1:0]         wr_en_i,
    input  logic [NWR-1:0][AW-1:0] wr_addr_i,
    input  logic [NWR-1:0]         wr_release_i,
    input  logic                   rsv_en_i,
    input  logic [AW-1:0]          rsv_addr_i,
    input  logic                   flush_i,
    output logic [AW:0]            busy_cnt_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] rel_mask;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    always_comb begin
        rel_mask = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && wr_release_i[w]) begin
                rel_mask[wr_addr_i[w]] = 1'b1;
            end
        end
    end

    // Reserve is applied last so a new producer beats both release and flush.
    always_comb begin
        busy_d = flush_i ? '0 : (busy_q & ~rel_mask);
        if (rsv_en_i) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd_busy_o = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_busy_o[r] = busy_q[rd_addr_i[r]] & ~rel_mask[rd_addr_i[r]];
        end
    end

    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with write-through bypass and an attached
// scoreboard that tracks registers with in-flight producers.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
    output logic [NRD-1:0][XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]           rd_busy_o,
    input  logic [NWR-1:0]           wr_en_i,
    input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
    input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
    input  logic [NWR-1:0]           wr_release_i,
    input  logic                     rsv_en_i,
    input  logic [AW-1:0]            rsv_addr_i,
    input  logic                     flush_i,
    output logic [AW:0]              busy_cnt_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Ascending port order makes the highest-index port win on address collisions.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w] != '0)) begin
                regs_d[wr_addr_i[w]] = wr_data_i[w];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_data_o[r] = regs_q[rd_addr_i[r]];
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[r]) && (rd_addr_i[r] != '0)) begin
                    rd_data_o[r] = wr_data_i[w];
                end
            end
            // Bypass data must not leak out while reset is held.
            if (!rst_n) begin
                rd_data_o[r] = '0;
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_i    (rd_addr_i),
        .rd_busy_o    (rd_busy_o),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_release_i (wr_release_i),
        .rsv_en_i     (rsv_en_i),
        .rsv_addr_i   (rsv_addr_i),
        .flush_i      (flush_i),
        .busy_cnt_o   (busy_cnt_o)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic against a simple
// array model, and a second instance with a 16x64, 3-read-port configuration.
module tb_reg_file_sb;
    import rf_pkg::*;

    localparam int NRD = 2;
    localparam int NWR = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_addr_t [NRD-1:0] rd_addr;
    xlen_t     [NRD-1:0] rd_data;
    logic      [NRD-1:0] rd_busy;
    logic      [NWR-1:0] wr_en;
    reg_addr_t [NWR-1:0] wr_addr;
    xlen_t     [NWR-1:0] wr_data;
    logic      [NWR-1:0] wr_rel;
    logic                rsv_en;
    reg_addr_t           rsv_addr;
    logic                flush;
    logic [5:0]          busy_cnt;

    // Second configuration: NREGS=16, XLEN=64, NRD=3, NWR=1
    logic [2:0][3:0]  b_rd_addr;
    logic [2:0][63:0] b_rd_data;
    logic [2:0]       b_rd_busy;
    logic [0:0]       b_wr_en;
    logic [0:0][3:0]  b_wr_addr;
    logic [0:0][63:0] b_wr_data;
    logic [0:0]       b_wr_rel;
    logic             b_rsv_en;
    logic [3:0]       b_rsv_addr;
    logic             b_flush;
    logic [4:0]       b_busy_cnt;

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_busy_o(rd_busy), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_release_i(wr_rel), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush),
        .busy_cnt_o(busy_cnt)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data),
        .rd_busy_o(b_rd_busy), .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr),
        .wr_data_i(b_wr_data), .wr_release_i(b_wr_rel), .rsv_en_i(b_rsv_en),
        .rsv_addr_i(b_rsv_addr), .flush_i(b_flush), .busy_cnt_o(b_busy_cnt)
    );

    // Reference model: architectural state as plain arrays
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        logic [31:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && int'(wr_addr[w]) == a) v = wr_data[w];
        return v;
    endfunction

    function automatic bit exp_busy(input int a);
        if (a == 0) return 1'b0;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wr_rel[w] && int'(wr_addr[w]) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    // Architectural effect of one clock edge with the current inputs
    function automatic void model_clock();
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wr_addr[w] != 0) m_regs[wr_addr[w]] = wr_data[w];
        if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wr_rel[w]) m_busy[wr_addr[w]] = 1'b0;
        if (rsv_en) m_busy[rsv_addr] = 1'b1;
        m_busy[0] = 1'b0;
    endfunction

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_rel = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic check_comb();
        #1;
        for (int r = 0; r < NRD; r++) begin
            check($sformatf("rd_data[%0d] x%0d", r, rd_addr[r]), 64'(rd_data[r]),
                  64'(exp_read(int'(rd_addr[r]))));
            check($sformatf("rd_busy[%0d] x%0d", r, rd_addr[r]), 64'(rd_busy[r]),
                  64'(exp_busy(int'(rd_addr[r]))));
        end
    endtask

    // Inputs are driven just after a negedge; checks comb outputs, clocks, checks count.
    task automatic step();
        check_comb();
        @(posedge clk);
        model_clock();
        #1;
        check("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rd_addr = '0;
        b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_wr_rel = '0;
        b_rsv_en = 1'b0; b_rsv_addr = '0; b_flush = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("busy_cnt after reset", 64'(busy_cnt), 64'd0);

        // Reset and x0: populate state, then assert reset mid-write/reservation
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'hAAAA_5555; step();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd6; step();
        idle(); wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h1234_5678;
        rsv_en = 1'b1; rsv_addr = 5'd8; rd_addr[0] = 5'd3; rd_addr[1] = 5'd6;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rd_data in reset", 64'(rd_data[0]), 64'd0);
        check("rd_busy in reset", 64'(rd_busy), 64'd0);
        @(posedge clk); #1;
        check("busy_cnt in reset", 64'(busy_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int a = 1; a < 32; a++) begin
            rd_addr[0] = reg_addr_t'(a); rd_addr[1] = reg_addr_t'(32 - a);
            #1;
            check($sformatf("post-reset x%0d", a), 64'(rd_data[0]), 64'd0);
            step();
        end
        wr_en = 2'b10; wr_addr[1] = 5'd0; wr_data[1] = 32'hDEADBEEF; wr_rel = 2'b10;
        rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr[0] = 5'd0;
        step();
        idle();
        #1;
        check("x0 read", 64'(rd_data[0]), 64'd0);
        check("x0 busy_cnt", 64'(busy_cnt), 64'd0);
        step();

        // Bypass with write-port collision
        wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
        wr_data[0] = 32'h1111; wr_data[1] = 32'h2222; rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
        #1;
        check("bypass collision", 64'(rd_data[0]), 64'h2222);
        step();
        idle();
        #1;
        check("after collision", 64'(rd_data[0]), 64'h2222);
        step();

        // Scoreboard flow on x7
        rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr[0] = 5'd7; step();
        idle();
        #1;
        check("x7 busy", 64'(rd_busy[0]), 64'd1);
        check("x7 busy_cnt", 64'(busy_cnt), 64'd1);
        step();
        wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h42; wr_rel = 2'b01;
        #1;
        check("x7 release bypass busy", 64'(rd_busy[0]), 64'd0);
        check("x7 write-through", 64'(rd_data[0]), 64'h42);
        step();
        idle();
        check("x7 busy_cnt after", 64'(busy_cnt), 64'd0);

        // Reserve/release collision on x9
        rsv_en = 1'b1; rsv_addr = 5'd9; step();
        wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h99; wr_rel = 2'b10;
        rsv_en = 1'b1; rsv_addr = 5'd9; step();
        idle(); rd_addr[0] = 5'd9;
        #1;
        check("x9 still busy", 64'(rd_busy[0]), 64'd1);
        check("x9 busy_cnt", 64'(busy_cnt), 64'd1);
        step();

        // Flush with same-cycle reservation
        for (int a = 1; a <= 4; a++) begin
            rsv_en = 1'b1; rsv_addr = reg_addr_t'(a); step();
        end
        idle(); flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd10; step();
        idle(); rd_addr[0] = 5'd10; rd_addr[1] = 5'd9;
        #1;
        check("flush busy_cnt", 64'(busy_cnt), 64'd1);
        check("x10 busy", 64'(rd_busy[0]), 64'd1);
        check("x9 flushed", 64'(rd_busy[1]), 64'd0);
        step();
        // Releasing a non-busy register changes nothing
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h33; wr_rel = 2'b01; step();
        idle(); step();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            for (int w = 0; w < NWR; w++) begin
                wr_en[w]   = ($urandom_range(0, 2) != 0);
                wr_addr[w] = reg_addr_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
                wr_data[w] = $urandom;
                wr_rel[w]  = ($urandom_range(0, 1) == 1);
            end
            for (int r = 0; r < NRD; r++)
                rd_addr[r] = reg_addr_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
            rsv_en   = ($urandom_range(0, 3) != 0);
            rsv_addr = reg_addr_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
            flush    = ($urandom_range(0, 31) == 0);
            step();
        end
        idle();

        // Second configuration: 16 x 64, three read ports
        b_wr_en = 1'b1; b_wr_addr[0] = 4'd15; b_wr_data[0] = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        b_wr_en = 1'b0; b_rd_addr[0] = 4'd15; b_rd_addr[1] = 4'd15; b_rd_addr[2] = 4'd15;
        #1;
        for (int r = 0; r < 3; r++)
            check($sformatf("b x15 port%0d", r), b_rd_data[r], 64'hFFFF_0000_FFFF_0000);
        for (int a = 1; a < 16; a++) begin
            b_rsv_en = 1'b1; b_rsv_addr = 4'(a);
            @(negedge clk);
        end
        b_rsv_addr = 4'd0;
        @(negedge clk);
        b_rsv_en = 1'b0;
        #1;
        check("b busy_cnt full", 64'(b_busy_cnt), 64'd15);
        check("b x15 busy", 64'(b_rd_busy), 64'b111);
        b_rd_addr[1] = 4'd0;
        #1;
        check("b x0 not busy", 64'(b_rd_busy[1]), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
